// File: rtl/button_pkg.sv
// Shared types and sizing helpers for the push-button conditioner.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } btn_state_t;

    // Width of a counter that must reach n-1, with one spare bit of headroom.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-flop synchroniser, counter debouncer and a
// press / hold-to-repeat / release pulse FSM, all outputs registered.
//
//   state  | meaning
//   IDLE   | debounced level is 0, waiting for a debounced rise
//   HOLD   | button held, counting the initial repeat delay
//   REPEAT | button held, emitting a pulse every repeat period
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic in_i,
    input  logic repeat_en_i,
    output logic level_o,
    output logic press_o,
    output logic pulse_o,
    output logic release_o
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int RW = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));

    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RD_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST  = RW'(REPEAT_PERIOD - 1);

    logic          s1_q, s2_q;
    logic          level_q, level_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    btn_state_t    state_q, state_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          press_q, press_d;
    logic          pulse_q, pulse_d;
    logic          release_q, release_d;

    logic mismatch;
    logic flip;
    logic rise;
    logic fall;

    assign mismatch = (s2_q != level_q);
    assign flip     = mismatch && (dcnt_q == DB_LAST);
    assign rise     = flip && s2_q;
    assign fall     = flip && !s2_q;

    always_comb begin
        level_d = level_q;
        dcnt_d  = dcnt_q;
        if (!mismatch) begin
            dcnt_d = '0;
        end else if (flip) begin
            level_d = s2_q;
            dcnt_d  = '0;
        end else begin
            dcnt_d = dcnt_q + DW'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        rcnt_d    = rcnt_q;
        press_d   = 1'b0;
        pulse_d   = 1'b0;
        release_d = 1'b0;

        // A debounced fall overrides any repeat that happens to be due.
        if (fall) begin
            state_d   = IDLE;
            rcnt_d    = '0;
            release_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d = HOLD;
                        rcnt_d  = '0;
                        press_d = 1'b1;
                        pulse_d = 1'b1;
                    end
                end
                HOLD: begin
                    if (!repeat_en_i) begin
                        rcnt_d = '0;
                    end else if (rcnt_q == RD_LAST) begin
                        state_d = REPEAT;
                        rcnt_d  = '0;
                        pulse_d = 1'b1;
                    end else begin
                        rcnt_d = rcnt_q + RW'(1);
                    end
                end
                REPEAT: begin
                    if (!repeat_en_i) begin
                        state_d = HOLD;
                        rcnt_d  = '0;
                    end else if (rcnt_q == RP_LAST) begin
                        rcnt_d  = '0;
                        pulse_d = 1'b1;
                    end else begin
                        rcnt_d = rcnt_q + RW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    rcnt_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            level_q   <= 1'b0;
            dcnt_q    <= '0;
            state_q   <= IDLE;
            rcnt_q    <= '0;
            press_q   <= 1'b0;
            pulse_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            s1_q      <= in_i;
            s2_q      <= s1_q;
            level_q   <= level_d;
            dcnt_q    <= dcnt_d;
            state_q   <= state_d;
            rcnt_q    <= rcnt_d;
            press_q   <= press_d;
            pulse_q   <= pulse_d;
            release_q <= release_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign pulse_o   = pulse_q;
    assign release_o = release_q;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel push-button front end: N_CH independent conditioned
// channels producing clean level, press, action-pulse and release strobes.
module button_conditioner
    import button_pkg::*;
#(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 4
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [N_CH-1:0] in_i,
    input  logic [N_CH-1:0] repeat_en_i,
    output logic [N_CH-1:0] level_o,
    output logic [N_CH-1:0] press_o,
    output logic [N_CH-1:0] pulse_o,
    output logic [N_CH-1:0] release_o
);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_channel (
            .clk_i       (clk_i),
            .reset_i     (reset_i),
            .in_i        (in_i[g]),
            .repeat_en_i (repeat_en_i[g]),
            .level_o     (level_o[g]),
            .press_o     (press_o[g]),
            .pulse_o     (pulse_o[g]),
            .release_o   (release_o[g])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised and directed bench for button_conditioner with a queue-based
// scoreboard fed by a run-length reference model of each channel.
module tb_button_conditioner;

    localparam int N  = 4;
    localparam int DB = 4;
    localparam int RD = 16;
    localparam int RP = 4;

    typedef struct packed {
        logic [N-1:0] level;
        logic [N-1:0] press;
        logic [N-1:0] pulse;
        logic [N-1:0] rel;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] in_r = '0;
    logic [N-1:0] en_r = '0;
    logic [N-1:0] level, press, pulse, rel;

    int checks   = 0;
    int failures = 0;

    exp_t sb[$];

    // Reference model state: synchroniser pipe, debounced level, length of
    // the current disagreement run, held flag and length of the current
    // uninterrupted repeat-enabled run since the press.
    int m_s1[N], m_s2[N], m_lvl[N], m_mis[N], m_run[N], m_held[N];

    button_conditioner #(
        .N_CH            (N),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk_i       (clk),
        .reset_i     (rst),
        .in_i        (in_r),
        .repeat_en_i (en_r),
        .level_o     (level),
        .press_o     (press),
        .pulse_o     (pulse),
        .release_o   (rel)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0;
            m_mis[c] = 0; m_run[c] = 0; m_held[c] = 0;
        end
    endtask

    task automatic model_edge(output exp_t e);
        e = '0;
        if (rst) begin
            model_reset();
            return;
        end
        for (int c = 0; c < N; c++) begin
            int old;
            int rise, fall;
            old = m_s2[c];
            m_s2[c] = m_s1[c];
            m_s1[c] = in_r[c] ? 1 : 0;
            rise = 0; fall = 0;
            if (old == m_lvl[c]) begin
                m_mis[c] = 0;
            end else begin
                m_mis[c]++;
                if (m_mis[c] == DB) begin
                    m_lvl[c] = old;
                    m_mis[c] = 0;
                    if (old == 1) rise = 1; else fall = 1;
                end
            end
            if (rise == 1) begin
                e.press[c] = 1'b1;
                e.pulse[c] = 1'b1;
                m_held[c] = 1;
                m_run[c] = 0;
            end else if (fall == 1) begin
                e.rel[c] = 1'b1;
                m_held[c] = 0;
                m_run[c] = 0;
            end else if (m_held[c] == 1) begin
                if (en_r[c]) begin
                    m_run[c]++;
                    if (m_run[c] >= RD && ((m_run[c] - RD) % RP) == 0)
                        e.pulse[c] = 1'b1;
                end else begin
                    m_run[c] = 0;
                end
            end
            e.level[c] = (m_lvl[c] == 1);
        end
    endtask

    task automatic step(input logic [N-1:0] i, input logic [N-1:0] en, input logic r);
        exp_t e;
        @(negedge clk);
        in_r = i;
        en_r = en;
        rst  = r;
        model_edge(e);
        sb.push_back(e);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({level, press, pulse, rel} !== '0) begin
            failures++;
            $display("FAIL %s: got lvl=%b prs=%b pls=%b rel=%b, required all 0",
                     name, level, press, pulse, rel);
        end
    endtask

    // Monitor: every clock edge presents a registered output vector.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (level !== e.level || press !== e.press || pulse !== e.pulse || rel !== e.rel) begin
                failures++;
                $display("FAIL outputs t=%0t: got lvl=%b prs=%b pls=%b rel=%b, required lvl=%b prs=%b pls=%b rel=%b",
                         $time, level, press, pulse, rel, e.level, e.press, e.pulse, e.rel);
            end
            checks++;
            if ((press & rel) !== '0) begin
                failures++;
                $display("FAIL press_release_overlap t=%0t: got %b, required 0", $time, press & rel);
            end
        end
    end

    initial begin
        logic [N-1:0] cur_in;
        logic [N-1:0] cur_en;
        logic [8:0]   bounce;
        model_reset();

        repeat (3) step('0, '0, 1'b1);
        check_zero("reset_state");
        repeat (4) step('0, '0, 1'b0);

        // Clean press on ch0, then let go.
        repeat (10) step(4'b0001, '0, 1'b0);
        repeat (10) step(4'b0000, '0, 1'b0);

        // Bounce on ch1, then a short glitch that must not register.
        bounce = 9'b111111011;
        for (int k = 0; k < 9; k++) step({2'b00, bounce[k], 1'b0}, '0, 1'b0);
        repeat (10) step(4'b0000, '0, 1'b0);
        repeat (3)  step(4'b0010, '0, 1'b0);
        repeat (10) step(4'b0000, '0, 1'b0);

        // Hold-to-repeat on ch2, then release.
        repeat (45) step(4'b0100, 4'b0100, 1'b0);
        repeat (10) step(4'b0000, 4'b0100, 1'b0);

        // Repeat enable dropped briefly while holding ch2.
        for (int k = 0; k < 60; k++)
            step(4'b0100, (k >= 24 && k < 28) ? 4'b0000 : 4'b0100, 1'b0);
        repeat (10) step(4'b0000, 4'b0000, 1'b0);

        // Simultaneous ch0/ch3 press, ch3 high too briefly to debounce.
        repeat (2)  step(4'b1001, '0, 1'b0);
        repeat (10) step(4'b0001, '0, 1'b0);
        repeat (10) step(4'b0000, '0, 1'b0);

        // Random traffic on all channels.
        cur_in = '0;
        cur_en = '0;
        for (int k = 0; k < 600; k++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 7) == 0)  cur_in[c] = ~cur_in[c];
                if ($urandom_range(0, 19) == 0) cur_en[c] = ~cur_en[c];
            end
            step(cur_in, cur_en, 1'b0);
        end
        repeat (10) step('0, '0, 1'b0);

        // Asynchronous reset between edges while ch2 is repeating.
        repeat (25) step(4'b0100, 4'b0100, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_reset_immediate");
        repeat (2)  step(4'b0100, 4'b0100, 1'b1);
        repeat (30) step(4'b0100, 4'b0100, 1'b0);
        repeat (10) step(4'b0000, 4'b0000, 1'b0);

        // Second random pass with fast-toggling inputs.
        cur_in = '0;
        cur_en = '1;
        for (int k = 0; k < 400; k++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 3) == 0)  cur_in[c] = ~cur_in[c];
                if ($urandom_range(0, 29) == 0) cur_en[c] = ~cur_en[c];
            end
            step(cur_in, cur_en, 1'b0);
        end

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Multi-channel push-button front end. Each channel has a 2-flop synchroniser, a counter-based debouncer, a one-cycle press/release pulse generator and an optional hold-to-repeat pulse train. Raw board keys and the voice-trigger strobe feed into it. Game-control logic (flap, start, pause) uses its clean single-cycle pulses.

Parameters:
- N_CH, 4, number of independent input channels (>=1).
- DEBOUNCE_CYCLES, 4, consecutive cycles the synchronised input must disagree with the debounced level before the level flips (>=1).
- REPEAT_DELAY, 16, cycles from the press pulse to the first repeat pulse (>=1).
- REPEAT_PERIOD, 4, cycles between later repeat pulses (>=1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in  in  N_CH  raw, asynchronous button levels, 1 = pressed
- repeat_en  in  N_CH  per-channel hold-to-repeat enable, synchronous
- level  out  N_CH  debounced level
- press  out  N_CH  one-cycle pulse on debounced 0->1 only
- pulse  out  N_CH  press OR repeat pulse (the action strobe)
- release  out  N_CH  one-cycle pulse on debounced 1->0

Behaviour:
- Reset is asynchronous, active-high. While reset is high:
  - all outputs, sync flops, counters and state are 0 / IDLE.
  - No pulse is emitted in the cycle reset deasserts.
  - Reset mid-hold or mid-debounce discards all progress.
- All outputs are registered. Channels are fully independent.
- Synchroniser: s1 <= in, s2 <= s1.
- Debounce counter dcnt (width clog2(DEBOUNCE_CYCLES)+1), evaluated each edge:
  - if s2 == level: dcnt <= 0.
  - else if dcnt == DEBOUNCE_CYCLES-1: level <= s2, dcnt <= 0.
  - else: dcnt++.
  - A single mismatch-free cycle (bounce) restarts the count.
- Latency: take the first edge sampling in=1 as edge 0, with in held stable. level and press go high after edge DEBOUNCE_CYCLES+1, i.e. edge 5 for the defaults. Release latency is symmetric.
- Per-channel FSM (rcnt width clog2(max(REPEAT_DELAY,REPEAT_PERIOD))+1):
  - IDLE: level 0. On debounced rise: press=1, pulse=1, rcnt<=0, go to HOLD.
  - HOLD:
    - if repeat_en=0: rcnt<=0, stay.
    - else if rcnt == REPEAT_DELAY-1: pulse=1, rcnt<=0, go to REPEAT.
    - else: rcnt++.
  - REPEAT:
    - if repeat_en=0: rcnt<=0, go to HOLD (delay restarts when re-enabled).
    - else if rcnt == REPEAT_PERIOD-1: pulse=1, rcnt<=0.
    - else: rcnt++.
  - Any state with debounced fall: release=1, go to IDLE, rcnt<=0.
- Timing: with press after edge E, the first repeat comes after edge E+REPEAT_DELAY and later ones after E+REPEAT_DELAY+k*REPEAT_PERIOD.
- Simultaneous events:
  - Release beats a repeat due in the same cycle: release=1, pulse=0.
  - press and release are never both high on one channel in one cycle.
- repeat_en=0 throughout: exactly one pulse per debounced press (same behaviour as the single-channel press filter).
- pulse, press and release are each exactly one cycle wide.

Decomposition:
- Package button_pkg holds:
  - typedef enum logic [1:0] {IDLE, HOLD, REPEAT} btn_state_t.
  - a counter-width helper function.
- One sub-module, button_channel:
  - covers sync + debounce + FSM for one channel, parameterised identically.
  - the top generates N_CH instances and concatenates their outputs.

Test Plan:
- Clean press, ch0, defaults: in[0] rises at edge 0 and holds 10 cycles.
  - Response: level[0]/press[0]/pulse[0] after edge 5; press one cycle only; release after the fall + 5 edges; other channels stay 0.
- Bounce, ch1: in[1] = 1,1,0,1,1,1,1 (toggle at cycle 2).
  - Response: no press until 4 consecutive mismatch counts after the glitch.
  - A 3-cycle high glitch produces no level change at all.
- Repeat, ch2, repeat_en[2]=1, held 40 cycles after press at edge E.
  - Response: pulse at E, E+16, E+20, E+24, E+28, ...
  - press only at E; release once on let-go with no pulse that cycle.
- Repeat toggle: repeat_en dropped at E+18, raised at E+22.
  - Response: no pulse E+18..E+37; next pulse at E+38.
- Simultaneous channels: ch0 and ch3 pressed the same cycle, ch3 released 2 cycles later.
  - Response: both press together.
  - ch3 shows no press if its high phase is shorter than the debounce.
- Asynchronous reset asserted mid-REPEAT, between clock edges.
  - Response: outputs 0 immediately, without waiting for clk.
  - After deassert with in still high: a fresh press only after DEBOUNCE_CYCLES+2 edges.
